la_ioring_pwrseq: RTL and testbench

LA_IORING_PWRSEQ -- requirements
Module: la_ioring_pwrseq

---
 rtl/la_iopkg.sv | 11 +
 rtl/la_ioseq_timer.sv | 29 ++
 rtl/la_ioring_pwrseq.sv | 131 +++++++++++++
 tb/tb_la_ioring_pwrseq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/la_iopkg.sv
// Shared IO-ring bus layout: segment-enable field base and isolation bit position.
package la_iopkg;

  localparam int IORING_SEG_BASE = 0;

  // The isolation bit sits directly above the segment-enable field.
  function automatic int ioring_iso_idx(input int nseg);
    return IORING_SEG_BASE + nseg;
  endfunction

endpackage

// File: rtl/la_ioseq_timer.sv
// Step timer: load captures D, done is high once D further cycles have elapsed,
// so a step begun by load ends D+1 edges later. Counts down and saturates at zero.
module la_ioseq_timer #(
  parameter int DLYW = 8
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            load,
  input  logic [DLYW-1:0] dly,
  output logic            done
);

  localparam logic [DLYW-1:0] CNT_ONE = DLYW'(1);

  logic [DLYW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= dly;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/la_ioring_pwrseq.sv
// IO-ring power sequencer: enables segments one step at a time on power-up, then
// removes isolation; power-down isolates first, then drops segments highest first.
module la_ioring_pwrseq
  import la_iopkg::*;
#(
  parameter      PROP  = "DEFAULT",
  parameter      SIDE  = "NO",
  parameter int  NSEG  = 4,
  parameter int  DLYW  = 8,
  parameter int  RINGW = 8
) (
  input  logic             clk,
  input  logic             nreset,
  inout  wire              vdd,
  inout  wire              vss,
  inout  wire              vddio,
  inout  wire              vssio,
  input  logic             en,
  input  logic [DLYW-1:0]  dly,
  output logic [NSEG-1:0]  seg_en,
  output logic             iso,
  output logic             ready,
  output logic             busy,
  output logic [RINGW-1:0] ioring
);

  typedef enum logic [1:0] {
    S_OFF,
    S_UP,
    S_ON,
    S_DN
  } state_t;

  localparam int            ISO_IDX = ioring_iso_idx(NSEG);
  localparam logic [NSEG-1:0] SEG_ONE = NSEG'(1);

  state_t          state, state_nxt;
  logic [NSEG-1:0] seg_nxt;
  logic            iso_nxt;
  logic            ready_nxt;
  logic            load;
  logic            done;

  la_ioseq_timer #(.DLYW(DLYW)) u_timer (
    .clk    (clk),
    .nreset (nreset),
    .load   (load),
    .dly    (dly),
    .done   (done)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state  <= S_OFF;
      seg_en <= '0;
      iso    <= 1'b1;
      ready  <= 1'b0;
    end else begin
      state  <= state_nxt;
      seg_en <= seg_nxt;
      iso    <= iso_nxt;
      ready  <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    seg_nxt   = seg_en;
    iso_nxt   = iso;
    ready_nxt = ready;
    load      = 1'b0;
    case (state)
      S_OFF: begin
        if (en) begin
          state_nxt = S_UP;
          load      = 1'b1;
        end
      end
      S_UP: begin
        // An abort wins over a step that happens to end on the same edge.
        if (!en) begin
          if (seg_en == '0) begin
            state_nxt = S_OFF;
          end else begin
            state_nxt = S_DN;
            load      = 1'b1;
          end
        end else if (done) begin
          if (&seg_en) begin
            state_nxt = S_ON;
            iso_nxt   = 1'b0;
            ready_nxt = 1'b1;
          end else begin
            seg_nxt = (seg_en << 1) | SEG_ONE;
            load    = 1'b1;
          end
        end
      end
      S_ON: begin
        if (!en) begin
          state_nxt = S_DN;
          iso_nxt   = 1'b1;
          ready_nxt = 1'b0;
          load      = 1'b1;
        end
      end
      S_DN: begin
        if (done) begin
          seg_nxt = seg_en >> 1;
          if ((seg_en >> 1) == '0) begin
            state_nxt = S_OFF;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_OFF;
      end
    endcase
  end

  assign busy = (state == S_UP) || (state == S_DN);

  always_comb begin
    ioring                          = '0;
    ioring[IORING_SEG_BASE +: NSEG] = seg_en;
    ioring[ISO_IDX]                 = iso;
  end

endmodule

// File: tb/tb_la_ioring_pwrseq.sv
// Bench for la_ioring_pwrseq: directed timing points plus random en/dly/reset traffic
// checked every cycle against a step-counting reference model.
module tb_la_ioring_pwrseq;

  logic       clk;
  logic       nreset;
  logic       en;
  logic [7:0] dly;
  logic [3:0] seg_en;
  logic       iso;
  logic       ready;
  logic       busy;
  logic [7:0] ioring;
  wire        vdd, vss, vddio, vssio;

  assign vdd   = 1'b1;
  assign vss   = 1'b0;
  assign vddio = 1'b1;
  assign vssio = 1'b0;

  la_ioring_pwrseq #(
    .PROP("DEFAULT"), .SIDE("NO"), .NSEG(4), .DLYW(8), .RINGW(8)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .vdd    (vdd),
    .vss    (vss),
    .vddio  (vddio),
    .vssio  (vssio),
    .en     (en),
    .dly    (dly),
    .seg_en (seg_en),
    .iso    (iso),
    .ready  (ready),
    .busy   (busy),
    .ioring (ioring)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: number of powered segments, cycles left in the current step.
  localparam int P_OFF = 0, P_UP = 1, P_ON = 2, P_DN = 3;
  int m_ph    = P_OFF;
  int m_segs  = 0;
  int m_left  = 0;
  bit m_iso   = 1'b1;
  bit m_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit e, input int d, input bit r);
    if (!r) begin
      m_ph = P_OFF; m_segs = 0; m_left = 0; m_iso = 1'b1; m_ready = 1'b0;
    end else begin
      case (m_ph)
        P_OFF: if (e) begin m_ph = P_UP; m_left = d + 1; end
        P_UP: begin
          if (!e) begin
            if (m_segs == 0) m_ph = P_OFF;
            else begin m_ph = P_DN; m_left = d + 1; end
          end else begin
            m_left--;
            if (m_left == 0) begin
              if (m_segs < 4) begin m_segs++; m_left = d + 1; end
              else begin m_iso = 1'b0; m_ready = 1'b1; m_ph = P_ON; end
            end
          end
        end
        P_ON: if (!e) begin m_ph = P_DN; m_iso = 1'b1; m_ready = 1'b0; m_left = d + 1; end
        default: begin
          m_left--;
          if (m_left == 0) begin
            m_segs--;
            if (m_segs == 0) m_ph = P_OFF;
            else m_left = d + 1;
          end
        end
      endcase
    end
  endtask

  task automatic compare_all();
    logic [3:0] es;
    es = 4'((32'd1 << m_segs) - 1);
    chk("seg_en", seg_en, es);
    chk("iso", iso, m_iso);
    chk("ready", ready, m_ready);
    chk("busy", busy, (m_ph == P_UP) || (m_ph == P_DN));
    chk("ioring", ioring, {3'b000, m_iso, es});
    chk("thermo", ((seg_en & (seg_en + 4'd1)) == 4'd0), 1);
    chk("rdy_imp", (!ready || (!iso && (&seg_en))), 1);
  endtask

  task automatic tick(input bit e, input int d, input bit r);
    en = e; dly = d[7:0]; nreset = r;
    @(posedge clk);
    model_edge(e, d, r);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) tick(0, 0, 0);
    chk("rst_seg", seg_en, 0);
    chk("rst_iso", iso, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
  endtask

  initial begin
    en = 1'b0; dly = 8'd0; nreset = 1'b0;
    do_reset();

    // Power-up with D=2; cycle 0 is the edge that samples en=1.
    for (int c = 0; c <= 15; c++) begin
      tick(1, 2, 1);
      case (c)
        2:  chk("up_c2", seg_en, 4'b0000);
        3:  chk("up_c3", seg_en, 4'b0001);
        6:  chk("up_c6", seg_en, 4'b0011);
        9:  chk("up_c9", seg_en, 4'b0111);
        12: begin chk("up_c12", seg_en, 4'b1111); chk("up_c12_iso", iso, 1); end
        14: chk("up_c14_rdy", ready, 0);
        15: begin chk("up_c15_rdy", ready, 1); chk("up_c15_iso", iso, 0); chk("up_c15_busy", busy, 0); end
        default: ;
      endcase
    end

    // Power-down: k counts cycles after the last en=1 edge.
    for (int k = 1; k <= 13; k++) begin
      tick(0, 2, 1);
      case (k)
        1:  begin chk("dn_iso", iso, 1); chk("dn_rdy", ready, 0); chk("dn_busy", busy, 1); end
        3:  chk("dn_k3", seg_en, 4'b1111);
        4:  chk("dn_k4", seg_en, 4'b0111);
        7:  chk("dn_k7", seg_en, 4'b0011);
        10: chk("dn_k10", seg_en, 4'b0001);
        12: chk("dn_k12_busy", busy, 1);
        13: begin chk("dn_k13", seg_en, 4'b0000); chk("dn_k13_busy", busy, 0); end
        default: ;
      endcase
    end

    // Abort mid power-up: en falls after cycle 7 with seg_en=0011.
    for (int k = 0; k <= 14; k++) begin
      tick(k <= 7, 2, 1);
      if (k >= 8) chk("abort_iso", iso, 1);
      case (k)
        7:  chk("ab_k7", seg_en, 4'b0011);
        10: chk("ab_k10", seg_en, 4'b0011);
        11: chk("ab_k11", seg_en, 4'b0001);
        13: chk("ab_k13", seg_en, 4'b0001);
        14: begin chk("ab_k14", seg_en, 4'b0000); chk("ab_k14_busy", busy, 0); end
        default: ;
      endcase
    end

    // D=0: one-cycle steps.
    for (int k = 0; k <= 5; k++) begin
      tick(1, 0, 1);
      case (k)
        1: chk("d0_k1", seg_en, 4'b0001);
        2: chk("d0_k2", seg_en, 4'b0011);
        3: chk("d0_k3", seg_en, 4'b0111);
        4: begin chk("d0_k4", seg_en, 4'b1111); chk("d0_k4_rdy", ready, 0); end
        5: chk("d0_k5_rdy", ready, 1);
        default: ;
      endcase
    end
    for (int k = 0; k < 6; k++) tick(0, 0, 1);

    // dly changed mid-step only affects the following step.
    for (int k = 0; k <= 8; k++) begin
      tick(1, (k == 0) ? 1 : 5, 1);
      case (k)
        1: chk("mid_k1", seg_en, 4'b0000);
        2: chk("mid_k2", seg_en, 4'b0001);
        7: chk("mid_k7", seg_en, 4'b0001);
        8: chk("mid_k8", seg_en, 4'b0011);
        default: ;
      endcase
    end
    do_reset();

    // Reset in the middle of power-up, then a fresh sequence.
    for (int k = 0; k <= 12; k++) begin
      tick(1, 2, (k == 8) ? 1'b0 : 1'b1);
      case (k)
        7:  chk("rs_k7", seg_en, 4'b0011);
        8:  begin chk("rs_k8_seg", seg_en, 0); chk("rs_k8_iso", iso, 1); chk("rs_k8_busy", busy, 0); end
        9:  chk("rs_k9_busy", busy, 1);
        11: chk("rs_k11", seg_en, 4'b0000);
        12: chk("rs_k12", seg_en, 4'b0001);
        default: ;
      endcase
    end
    do_reset();

    // Maximum delay must not wrap early.
    for (int k = 0; k <= 256; k++) begin
      tick(1, 255, 1);
      if (k == 255) chk("dmax_k255", seg_en, 4'b0000);
      if (k == 256) chk("dmax_k256", seg_en, 4'b0001);
    end
    do_reset();

    // Re-request during power-down: DN completes, OFF for one cycle, then UP again.
    for (int k = 0; k < 12; k++) tick(1, 1, 1);
    chk("rr_on", ready, 1);
    for (int j = 0; j <= 11; j++) begin
      tick(j != 0, 1, 1);
      case (j)
        7:  chk("rr_j7", seg_en, 4'b0001);
        8:  begin chk("rr_j8", seg_en, 4'b0000); chk("rr_j8_busy", busy, 0); end
        9:  chk("rr_j9_busy", busy, 1);
        11: chk("rr_j11", seg_en, 4'b0001);
        default: ;
      endcase
    end

    // Random traffic against the model.
    begin
      bit e_r;
      e_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 11) == 0) e_r = ~e_r;
        tick(e_r, ($urandom_range(0, 19) == 0) ? $urandom_range(0, 255) % 9 : $urandom_range(0, 3),
             ($urandom_range(0, 199) != 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
